cache_mem_port: RTL and testbench

//  Memory-side responder for the cache miss/writeback interface. Accepts the cache's
//  mem_read_req/mem_write_req four-phase handshakes, serialises them onto one

---
 rtl/cache_mem_port.sv | 201 ++++++++++++++++++++
 tb/tb_cache_mem_port.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_port.sv
// rtl/cache_mem_port.sv - cache miss/writeback responder serialising onto one memory_async port
//
// Purpose:
//   Accepts the cache's four-phase read and write(back) handshakes and runs them one
//   at a time on a single memory_async master port. Writes win over reads in IDLE so
//   a dirty line is written back before its refill. Every output is registered.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   c_read_*          cache read request/address in, read data/ack out
//   c_write_*         cache write request/address/data in, write ack out
//   m_enable          memory master_enable
//   m_read_write      1 = read, 0 = write
//   m_addr/m_data_out address and write data, latched at grant
//   m_data_in/m_ack   memory read data and ack
//   error             sticky wait-timeout flag
//
// Configuration:
//   CACHE_MEM_PORT_TIMEOUT_EN  when defined, a 16-bit wait counter aborts a memory
//                              access after TIMEOUT cycles and sets error; otherwise
//                              the port waits for m_ack forever and error is 0.

module cache_mem_port #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_read_req,
  input  logic [WIDTH-1:0] c_read_addr,
  output logic [WIDTH-1:0] c_read_data,
  output logic             c_read_ack,
  input  logic             c_write_req,
  input  logic [WIDTH-1:0] c_write_addr,
  input  logic [WIDTH-1:0] c_write_data,
  output logic             c_write_ack,
  output logic             m_enable,
  output logic             m_read_write,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_data_out,
  input  logic [WIDTH-1:0] m_data_in,
  input  logic             m_ack,
  output logic             error
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD      = 3'd1;
  localparam logic [2:0] WR      = 3'd2;
  localparam logic [2:0] RD_DONE = 3'd3;
  localparam logic [2:0] WR_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rack_q, rack_d;
  logic             wack_q, wack_d;
  logic             en_q, en_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

`ifdef CACHE_MEM_PORT_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic        expired;

  // Fires on the TIMEOUT-th cycle spent waiting in RD/WR.
  assign expired = (wait_q == 16'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rack_d  = rack_q;
    wack_d  = wack_q;
    en_d    = en_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        // A stale m_ack (e.g. left over from a reset mid-access) blocks new grants.
        if (!m_ack) begin
          if (c_write_req) begin
            state_d = WR;
            addr_d  = c_write_addr;
            wdata_d = c_write_data;
            en_d    = 1'b1;
            rw_d    = 1'b0;
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
            wait_d  = '0;
`endif
          end else if (c_read_req) begin
            state_d = RD;
            addr_d  = c_read_addr;
            en_d    = 1'b1;
            rw_d    = 1'b1;
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
            wait_d  = '0;
`endif
          end
        end
      end
      RD: begin
        if (m_ack) begin
          rdata_d = m_data_in;
          rack_d  = 1'b1;
          en_d    = 1'b0;
          state_d = RD_DONE;
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
        end else if (expired) begin
          rdata_d = '0;
          rack_d  = 1'b1;
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = RD_DONE;
        end else begin
          wait_d  = wait_q + 16'd1;
`endif
        end
      end
      WR: begin
        if (m_ack) begin
          wack_d  = 1'b1;
          en_d    = 1'b0;
          state_d = WR_DONE;
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
        end else if (expired) begin
          wack_d  = 1'b1;
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = WR_DONE;
        end else begin
          wait_d  = wait_q + 16'd1;
`endif
        end
      end
      // Finish the four-phase handshake on both sides before going idle.
      RD_DONE: begin
        if (!c_read_req && !m_ack) begin
          rack_d  = 1'b0;
          state_d = IDLE;
        end
      end
      WR_DONE: begin
        if (!c_write_req && !m_ack) begin
          wack_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      rack_q  <= 1'b0;
      wack_q  <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      rack_q  <= rack_d;
      wack_q  <= wack_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  assign c_read_data  = rdata_q;
  assign c_read_ack   = rack_q;
  assign c_write_ack  = wack_q;
  assign m_enable     = en_q;
  assign m_read_write = rw_q;
  assign m_addr       = addr_q;
  assign m_data_out   = wdata_q;
`ifdef CACHE_MEM_PORT_TIMEOUT_EN
  assign error        = err_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_cache_mem_port.sv
// tb/tb_cache_mem_port.sv - directed vectors for cache_mem_port against a memory_async model

module tb_cache_mem_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        c_read_req = 1'b0;
  logic [31:0] c_read_addr = '0;
  logic [31:0] c_read_data;
  logic        c_read_ack;
  logic        c_write_req = 1'b0;
  logic [31:0] c_write_addr = '0;
  logic [31:0] c_write_data = '0;
  logic        c_write_ack;
  logic        m_enable;
  logic        m_read_write;
  logic [31:0] m_addr;
  logic [31:0] m_data_out;
  logic        m_ack;
  logic        error;

  always #5 clk = ~clk;

  cache_mem_port #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .c_read_req(c_read_req), .c_read_addr(c_read_addr), .c_read_data(c_read_data),
    .c_read_ack(c_read_ack),
    .c_write_req(c_write_req), .c_write_addr(c_write_addr), .c_write_data(c_write_data),
    .c_write_ack(c_write_ack),
    .m_enable(m_enable), .m_read_write(m_read_write), .m_addr(m_addr),
    .m_data_out(m_data_out), .m_data_in(m_data_in), .m_ack(m_ack), .error(error)
  );

  // memory_async model: ack after mem_latency enabled cycles, held while enabled,
  // dropped the cycle after m_enable falls. Unwritten word i reads 0x1000_0000+i.
  int          mem_latency = 3;
  bit          mem_hang = 1'b0;
  bit          force_ack = 1'b0;
  bit          ack_r;
  int          lat_cnt;
  bit   [31:0] m_data_in;
  bit          written [256];
  logic [31:0] wmem    [256];

  assign m_ack = ack_r | force_ack;

  function automatic logic [31:0] mem_word(input logic [7:0] idx);
    return written[idx] ? wmem[idx] : (32'h1000_0000 + {24'd0, idx});
  endfunction

  always @(posedge clk) begin
    if (m_enable && !ack_r && !mem_hang) begin
      if (lat_cnt >= mem_latency - 1) begin
        ack_r   <= 1'b1;
        lat_cnt <= 0;
        if (m_read_write) m_data_in <= mem_word(m_addr[9:2]);
        else begin
          wmem[m_addr[9:2]]    <= m_data_out;
          written[m_addr[9:2]] <= 1'b1;
        end
      end else lat_cnt <= lat_cnt + 1;
    end else if (!m_enable) begin
      ack_r   <= 1'b0;
      lat_cnt <= 0;
    end
  end

  // Grant log and latched-value stability monitor.
  bit          g_rw   [$];
  logic [31:0] g_addr [$];
  logic [31:0] g_data [$];
  bit          prev_en;
  logic [31:0] prev_addr, prev_data;
  bit          prev_rw;
  int          stable_err = 0;

  always @(negedge clk) begin
    if (m_enable && !prev_en) begin
      g_rw.push_back(m_read_write);
      g_addr.push_back(m_addr);
      g_data.push_back(m_data_out);
    end
    if (m_enable && prev_en &&
        (m_addr !== prev_addr || m_data_out !== prev_data || m_read_write !== prev_rw))
      stable_err++;
    prev_en   = m_enable;
    prev_addr = m_addr;
    prev_data = m_data_out;
    prev_rw   = m_read_write;
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Full four-phase transaction; lat = negedges from raising req to seeing ack.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat, output bit ok);
    int n;
    ok  = 1'b1;
    lat = 0;
    if (wr) begin
      c_write_addr = addr; c_write_data = wdata; c_write_req = 1'b1;
    end else begin
      c_read_addr = addr; c_read_req = 1'b1;
    end
    while (!(wr ? c_write_ack : c_read_ack)) begin
      @(negedge clk);
      lat++;
      if (lat > 500) begin ok = 1'b0; break; end
    end
    rdata = c_read_data;
    if (wr) c_write_req = 1'b0; else c_read_req = 1'b0;
    n = 0;
    while (wr ? c_write_ack : c_read_ack) begin
      @(negedge clk);
      n++;
      if (n > 20) begin ok = 1'b0; break; end
    end
    idle(2);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vt [9];
  logic [31:0] rd;
  int          lat, gi, n, hi;
  bit          ok, seen, hold_ok;

  initial begin
    vt[0] = '{1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 32'h0,         3};
    vt[1] = '{1'b0, 32'h0000_000C, 32'h0,         32'hDEAD_BEEF, 3};
    vt[2] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         1};
    vt[3] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1};
    vt[4] = '{1'b0, 32'h0000_0024, 32'h0,         32'h1000_0009, 2};
    vt[5] = '{1'b1, 32'h0000_000C, 32'h0000_0000, 32'h0,         5};
    vt[6] = '{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0000, 5};
    vt[7] = '{1'b0, 32'h0000_03FC, 32'h0,         32'h1000_00FF, 1};
    vt[8] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,         1};

    idle(2);
    chk("reset_outputs",
        {c_read_ack, c_write_ack, m_enable, m_read_write, error, c_read_data, m_addr, m_data_out},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 96'd0});
    reset = 1'b1;
    idle(2);

    // Read with a slow memory: grant next edge, ack latency + 1 edges later.
    mem_latency = 30;
    gi = g_rw.size();
    run_txn(1'b0, 32'h004, 32'h0, rd, lat, ok);
    chk("lat30_done", ok, 1'b1);
    chk("lat30_cycles", lat, 32);
    chk("lat30_data", rd, 32'h1000_0001);
    chk("lat30_grant", {g_rw[gi], g_addr[gi]}, {1'b1, 32'h004});

    for (int i = 0; i < 9; i++) begin
      mem_latency = vt[i].lat;
      gi = g_rw.size();
      run_txn(vt[i].wr, vt[i].addr, vt[i].wdata, rd, lat, ok);
      chk($sformatf("vec%0d_done", i), ok, 1'b1);
      chk($sformatf("vec%0d_grant", i), {g_rw[gi], g_addr[gi]}, {~vt[i].wr, vt[i].addr});
      if (vt[i].wr) chk($sformatf("vec%0d_wdata", i), g_data[gi], vt[i].wdata);
      else          chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
    end

    // Read and write raised together: write goes first, read follows.
    mem_latency = 4;
    gi = g_rw.size();
    c_read_addr = 32'h010; c_write_addr = 32'h018; c_write_data = 32'hCAFE_0018;
    c_read_req = 1'b1; c_write_req = 1'b1;
    n = 0;
    while (!c_write_ack && n < 100) begin @(negedge clk); n++; end
    chk("both_write_ack", c_write_ack, 1'b1);
    chk("both_read_waits", c_read_ack, 1'b0);
    c_write_req = 1'b0;
    n = 0;
    while (!c_read_ack && n < 100) begin @(negedge clk); n++; end
    chk("both_read_ack", c_read_ack, 1'b1);
    chk("both_read_data", c_read_data, 32'h1000_0004);
    c_read_req = 1'b0;
    idle(6);
    chk("both_grant_order", {g_rw.size() - gi, g_rw[gi], g_addr[gi], g_rw[gi+1], g_addr[gi+1]},
        {32'd2, 1'b0, 32'h018, 1'b1, 32'h010});
    chk("both_write_mem", mem_word(8'd6), 32'hCAFE_0018);

    // Requester holds req five cycles after ack: ack held, no new access.
    c_read_addr = 32'h014; c_read_req = 1'b1;
    n = 0;
    while (!c_read_ack && n < 100) begin @(negedge clk); n++; end
    gi = g_rw.size();
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!c_read_ack || m_enable) hold_ok = 1'b0;
    end
    chk("hold_ack_kept", {hold_ok, g_rw.size() - gi}, {1'b1, 32'd0});
    chk("hold_data", c_read_data, 32'h1000_0005);
    c_read_req = 1'b0;
    idle(4);
    chk("hold_ack_dropped", c_read_ack, 1'b0);

    // Request withdrawn mid-access: access completes, ack comes and goes by itself.
    gi = g_rw.size();
    c_read_addr = 32'h028; c_read_req = 1'b1;
    idle(2);
    c_read_req = 1'b0;
    seen = 1'b0; hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (c_read_ack) begin seen = 1'b1; hi++; end
    end
    chk("drop_ack_pulse", {seen, hi >= 1 && hi <= 2, c_read_ack}, {1'b1, 1'b1, 1'b0});
    chk("drop_one_grant", g_rw.size() - gi, 1);

    // A lingering m_ack keeps IDLE from granting.
    force_ack = 1'b1;
    c_read_addr = 32'h008; c_read_req = 1'b1;
    idle(4);
    chk("stale_ack_blocks", m_enable, 1'b0);
    force_ack = 1'b0;
    run_txn(1'b0, 32'h008, 32'h0, rd, lat, ok);
    chk("stale_ack_then_read", {ok, rd}, {1'b1, 32'h1000_0002});

    // Reset during a write: outputs clear at once, aborted write never lands.
    mem_latency = 30;
    c_write_addr = 32'h040; c_write_data = 32'hA5A5_A5A5; c_write_req = 1'b1;
    idle(5);
    chk("pre_reset_busy", {m_enable, m_addr, m_data_out}, {1'b1, 32'h040, 32'hA5A5_A5A5});
    reset = 1'b0;
    #1;
    chk("reset_mid_outputs",
        {c_read_ack, c_write_ack, m_enable, m_read_write, error, c_read_data, m_addr, m_data_out},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 96'd0});
    c_write_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    chk("post_reset_idle", {m_enable, c_write_ack, c_read_ack}, 3'b000);
    mem_latency = 2;
    run_txn(1'b0, 32'h040, 32'h0, rd, lat, ok);
    chk("post_reset_read", {ok, rd}, {1'b1, 32'h1000_0010});

`ifdef CACHE_MEM_PORT_TIMEOUT_EN
    // Memory never answers: abort at the 8th wait cycle with zero data.
    mem_hang = 1'b1;
    run_txn(1'b0, 32'h030, 32'h0, rd, lat, ok);
    chk("timeout_done", ok, 1'b1);
    chk("timeout_cycles", lat, 9);
    chk("timeout_data_err", {rd, error}, {32'h0, 1'b1});
    mem_hang = 1'b0;
    run_txn(1'b0, 32'h004, 32'h0, rd, lat, ok);
    chk("timeout_sticky", {ok, rd, error}, {1'b1, 32'h1000_0001, 1'b1});
`else
    chk("error_tied_low", error, 1'b0);
`endif

    chk("latched_stable", stable_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
